// File: rtl/mic_frame_reader.sv
// mic_frame_reader: read-side controller for the mic sample store.
// Accepts a frame request, pulses the store's read-start, then registers
// the contiguous burst from q_a into an indexed valid/last stream. Samples
// whose read address was stolen by a write are flagged and counted.
module mic_frame_reader #(
    parameter int MAW    = 10,
    parameter int RD_LAT = 2,
    parameter int DW     = 18,
    parameter int ECW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           frame_req,
    input  logic [3:0]     sel_addr_wth,
    input  logic [DW-1:0]  q_a,
    input  logic           wr_mic_en,
    output logic           rd_mic_start,
    output logic           busy,
    output logic [DW-1:0]  sample_out,
    output logic           sample_valid,
    output logic           sample_last,
    output logic [MAW-1:0] sample_idx,
    output logic           sample_err,
    output logic           frame_done,
    output logic [ECW-1:0] frame_err_cnt
);

    typedef enum logic [2:0] {IDLE, START, WAIT, STREAM, DONE} state_t;

    // Index/length are one bit wider than the address so N = 2^MAW is representable.
    localparam int NW  = MAW + 1;
    // WAIT counts 0 .. RD_LAT-2.
    localparam int WCW = (RD_LAT > 2) ? $clog2(RD_LAT - 1) : 1;

    state_t           state_q, state_d;
    logic             pending_q, pending_d;
    logic             armed_q, armed_d;
    logic             wr_dly_q, wr_dly_d;
    logic [WCW-1:0]   wait_q, wait_d;
    logic [NW-1:0]    n_q, n_d;
    logic [NW-1:0]    cnt_q, cnt_d;
    logic             rd_start_q, rd_start_d;
    logic [DW-1:0]    out_q, out_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic [MAW-1:0]   idx_q, idx_d;
    logic             err_q, err_d;
    logic             done_q, done_d;
    logic [ECW-1:0]   err_cnt_q, err_cnt_d;

    logic             go_start;
    int               w;
    logic [NW-1:0]    n_new;

    // Next-state and registered-output computation for the frame FSM.
    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        armed_d    = 1'b1;
        wr_dly_d   = wr_mic_en;
        wait_d     = wait_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        rd_start_d = 1'b0;
        out_d      = out_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        idx_d      = '0;
        err_d      = 1'b0;
        done_d     = 1'b0;
        err_cnt_d  = err_cnt_q;
        go_start   = 1'b0;

        // Frame size is clamped to the store's address width.
        if (int'(sel_addr_wth) > MAW) w = MAW;
        else                          w = int'(sel_addr_wth);
        n_new = NW'(1) << w;

        case (state_q)
            IDLE: begin
                // armed_q keeps a request coinciding with reset release from being taken.
                if (armed_q && (frame_req || pending_q)) begin
                    go_start  = 1'b1;
                    pending_d = 1'b0;
                end
            end
            START: begin
                pending_d = pending_q | frame_req;
                wait_d    = '0;
                state_d   = (RD_LAT > 1) ? WAIT : STREAM;
            end
            WAIT: begin
                pending_d = pending_q | frame_req;
                if (wait_q == WCW'(RD_LAT - 2)) state_d = STREAM;
                else                            wait_d  = wait_q + 1'b1;
            end
            STREAM: begin
                pending_d = pending_q | frame_req;
                if (last_q) begin
                    // Last sample is on the outputs this cycle; close the frame.
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    out_d   = q_a;
                    valid_d = 1'b1;
                    idx_d   = cnt_q[MAW-1:0];
                    last_d  = (cnt_q == n_q - 1'b1);
                    // The write that stole this sample's address happened one cycle earlier.
                    err_d   = wr_dly_q;
                    if (wr_dly_q && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                // A request arriving in DONE is still a busy-time request.
                pending_d = frame_req;
                if (pending_q) go_start = 1'b1;
                else           state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (go_start) begin
            state_d    = START;
            rd_start_d = 1'b1;
            n_d        = n_new;
            cnt_d      = '0;
            err_cnt_d  = '0;
        end
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            armed_q    <= 1'b0;
            wr_dly_q   <= 1'b0;
            wait_q     <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            rd_start_q <= 1'b0;
            out_q      <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            idx_q      <= '0;
            err_q      <= 1'b0;
            done_q     <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            armed_q    <= armed_d;
            wr_dly_q   <= wr_dly_d;
            wait_q     <= wait_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            rd_start_q <= rd_start_d;
            out_q      <= out_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            err_q      <= err_d;
            done_q     <= done_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign rd_mic_start  = rd_start_q;
    assign sample_out    = out_q;
    assign sample_valid  = valid_q;
    assign sample_last   = last_q;
    assign sample_idx    = idx_q;
    assign sample_err    = err_q;
    assign frame_done    = done_q;
    assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_mic_frame_reader.sv
// Bench for mic_frame_reader: random store data and write strobes, with a
// per-cycle history of q_a/wr_mic_en and a frame-level reference model.
module tb_mic_frame_reader;
  localparam int MAW    = 10;
  localparam int RD_LAT = 2;
  localparam int DW     = 18;
  localparam int ECW    = 8;
  localparam int HMAX   = 16384;
  localparam int EMAX   = (1 << ECW) - 1;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           frame_req = 1'b0;
  logic [3:0]     sel = '0;
  logic [DW-1:0]  q_a = '0;
  logic           wr = 1'b0;
  logic           rd_mic_start, busy, sample_valid, sample_last, sample_err, frame_done;
  logic [DW-1:0]  sample_out;
  logic [MAW-1:0] sample_idx;
  logic [ECW-1:0] frame_err_cnt;

  mic_frame_reader #(.MAW(MAW), .RD_LAT(RD_LAT), .DW(DW), .ECW(ECW)) dut (
    .clk(clk), .rst_n(rst_n), .frame_req(frame_req), .sel_addr_wth(sel),
    .q_a(q_a), .wr_mic_en(wr), .rd_mic_start(rd_mic_start), .busy(busy),
    .sample_out(sample_out), .sample_valid(sample_valid), .sample_last(sample_last),
    .sample_idx(sample_idx), .sample_err(sample_err), .frame_done(frame_done),
    .frame_err_cnt(frame_err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed { int c; logic [DW-1:0] d; logic [MAW-1:0] idx; logic last; logic err; } ev_t;
  typedef struct packed { int c; logic [ECW-1:0] cnt; } done_t;

  ev_t   vq[$];
  done_t dq[$];
  int    rsq[$];
  logic [DW-1:0] q_hist [HMAX];
  bit            wr_hist [HMAX];
  logic [DW-1:0] prev_out = '0;
  int bad_idle = 0, bad_hold = 0;
  int checks = 0, errors = 0;
  int wr_mode = 0;
  int s_cur = 0;

  // Observer: records input history and output events mid-cycle.
  always @(negedge clk) begin
    if (cyc < HMAX) begin q_hist[cyc] = q_a; wr_hist[cyc] = wr; end
    if (rst_n) begin
      if (rd_mic_start) rsq.push_back(cyc);
      if (sample_valid) vq.push_back('{c: cyc, d: sample_out, idx: sample_idx, last: sample_last, err: sample_err});
      else begin
        if (sample_idx !== '0 || sample_last !== 1'b0 || sample_err !== 1'b0) bad_idle++;
        if (sample_out !== prev_out) bad_hold++;
      end
      if (frame_done) dq.push_back('{c: cyc, cnt: frame_err_cnt});
    end
    prev_out = sample_out;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
    q_a = DW'($urandom);
    case (wr_mode)
      0: wr = 1'b0;
      1: wr = 1'($urandom_range(0, 1));
      2: wr = 1'b1;
      default: wr = (cyc == s_cur + RD_LAT - 1 + 3) || (cyc == s_cur + RD_LAT - 1 + 9);
    endcase
  endtask

  task automatic wait_done(input int k, input int bound, input string tag);
    int t = 0;
    while (dq.size() < k && t < bound) begin step(); t++; end
    checks++;
    if (dq.size() < k) begin
      errors++;
      $display("FAIL %s frame_done timeout: got %0d frames, expected %0d", tag, dq.size(), k);
    end
  endtask

  // Frame scoreboard: sample i comes from q_a at S+RD_LAT+i, is flagged by
  // wr at S+RD_LAT-1+i, and is shown at S+RD_LAT+1+i.
  task automatic scoreboard_frame(input int s, input int n, input string tag);
    int sum = 0;
    int s0;
    ev_t e;
    done_t d;
    logic [ECW-1:0] xcnt;
    checks++;
    if (rsq.size() == 0) begin
      errors++; $display("FAIL %s rd_mic_start missing, expected cycle %0d", tag, s);
    end else begin
      s0 = rsq.pop_front();
      if (s0 !== s) begin errors++; $display("FAIL %s rd_mic_start cycle: got %0d expected %0d", tag, s0, s); end
    end
    for (int i = 0; i < n; i++) begin
      logic [DW-1:0] xd;
      logic xe;
      xd = q_hist[s + RD_LAT + i];
      xe = wr_hist[s + RD_LAT - 1 + i];
      sum += int'(xe);
      checks++;
      if (vq.size() == 0) begin
        errors++; $display("FAIL %s sample %0d missing (expected %0d samples)", tag, i, n);
        break;
      end
      e = vq.pop_front();
      if (e.c !== s + RD_LAT + 1 + i) begin errors++; $display("FAIL %s sample %0d cycle: got %0d expected %0d", tag, i, e.c, s + RD_LAT + 1 + i); end
      checks++;
      if (e.d !== xd) begin errors++; $display("FAIL %s sample %0d data: got %h expected %h", tag, i, e.d, xd); end
      checks++;
      if (e.idx !== MAW'(i)) begin errors++; $display("FAIL %s sample %0d idx: got %0d expected %0d", tag, i, e.idx, i); end
      checks++;
      if (e.last !== (i == n - 1)) begin errors++; $display("FAIL %s sample %0d last: got %b expected %b", tag, i, e.last, (i == n - 1)); end
      checks++;
      if (e.err !== xe) begin errors++; $display("FAIL %s sample %0d err: got %b expected %b", tag, i, e.err, xe); end
    end
    xcnt = ECW'((sum > EMAX) ? EMAX : sum);
    checks++;
    if (dq.size() == 0) begin
      errors++; $display("FAIL %s frame_done missing", tag);
    end else begin
      d = dq.pop_front();
      if (d.c !== s + RD_LAT + n + 1) begin errors++; $display("FAIL %s frame_done cycle: got %0d expected %0d", tag, d.c, s + RD_LAT + n + 1); end
      checks++;
      if (d.cnt !== xcnt) begin errors++; $display("FAIL %s frame_err_cnt: got %0d expected %0d", tag, d.cnt, xcnt); end
    end
  endtask

  task automatic run_frame(input logic [3:0] sel_v, input int mode, input string tag);
    int n;
    n = 1 << ((int'(sel_v) > MAW) ? MAW : int'(sel_v));
    wr_mode = mode;
    sel = sel_v;
    frame_req = 1'b1;
    s_cur = cyc + 1;
    step();
    frame_req = 1'b0;
    sel = 4'($urandom);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL %s busy at start: got %b expected 1", tag, busy); end
    wait_done(1, n + 20, tag);
    scoreboard_frame(s_cur, n, tag);
    checks++;
    if (busy !== 1'b0 || vq.size() != 0) begin
      errors++; $display("FAIL %s after frame: busy %b extra samples %0d, expected 0 and 0", tag, busy, vq.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; frame_req = 1'b1;
    repeat (3) step();
    checks++;
    if ({rd_mic_start, busy, sample_valid, sample_last, sample_err, frame_done} !== 6'b0 ||
        sample_out !== '0 || sample_idx !== '0 || frame_err_cnt !== '0) begin
      errors++; $display("FAIL reset outputs: got busy %b valid %b out %h cnt %0d, expected all 0", busy, sample_valid, sample_out, frame_err_cnt);
    end
    rst_n = 1'b1;
    step();
    frame_req = 1'b0;
    repeat (4) step();
    checks++;
    if (rsq.size() != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release_req: got %0d starts busy %b, expected 0 starts busy 0", rsq.size(), busy);
    end
    rsq.delete();
  endtask

  task automatic test_basic();
    run_frame(4'd3, 0, "basic");
  endtask

  task automatic test_collision();
    run_frame(4'd4, 3, "collision_directed");
    run_frame(4'd5, 1, "collision_random");
  endtask

  task automatic test_random_frames();
    for (int k = 0; k < 6; k++) run_frame(4'($urandom_range(0, 7)), int'($urandom_range(0, 2)), "random");
  endtask

  task automatic test_size_limits();
    run_frame(4'd0, 1, "size_one");
    run_frame(4'd15, 1, "size_max");
  endtask

  task automatic test_saturation();
    run_frame(4'd9, 2, "saturation");
    repeat (3) step();
    checks++;
    if (frame_err_cnt !== ECW'(EMAX)) begin
      errors++; $display("FAIL saturation hold: got %0d expected %0d", frame_err_cnt, EMAX);
    end
  endtask

  task automatic test_back_to_back();
    int n = 4, len, h = 20, c, s1, nf;
    len = RD_LAT + n + 2;
    wr_mode = 1;
    sel = 4'd2;
    c = cyc;
    s1 = c + 1;
    frame_req = 1'b1;
    for (int k = 1; k < h; k++) step();
    step();
    frame_req = 1'b0;
    // A request seen during frame k queues frame k+1.
    nf = 1;
    while (c + h - 1 >= s1 + (nf - 1) * len) nf++;
    wait_done(nf, nf * len + 20, "b2b");
    checks++;
    if (rsq.size() != nf) begin errors++; $display("FAIL b2b frame count: got %0d expected %0d", rsq.size(), nf); end
    for (int k = 0; k < nf; k++) scoreboard_frame(s1 + k * len, n, "b2b");
    repeat (4) step();
    checks++;
    if (busy !== 1'b0 || rsq.size() != 0) begin
      errors++; $display("FAIL b2b trailing: busy %b extra starts %0d, expected 0 and 0", busy, rsq.size());
    end
    rsq.delete(); dq.delete(); vq.delete();
  endtask

  task automatic test_reset_midframe();
    int t = 0;
    wr_mode = 0;
    sel = 4'd3;
    frame_req = 1'b1;
    s_cur = cyc + 1;
    step();
    frame_req = 1'b0;
    while (cyc < s_cur + RD_LAT + 1 + 5 && t < 40) begin step(); t++; end
    checks++;
    if (sample_valid !== 1'b1 || sample_idx !== MAW'(5)) begin
      errors++; $display("FAIL midreset pre: got valid %b idx %0d expected 1 and 5", sample_valid, sample_idx);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({rd_mic_start, busy, sample_valid, sample_last, sample_err, frame_done} !== 6'b0 ||
        sample_out !== '0 || sample_idx !== '0 || frame_err_cnt !== '0) begin
      errors++; $display("FAIL midreset outputs: got busy %b valid %b out %h idx %0d, expected all 0", busy, sample_valid, sample_out, sample_idx);
    end
    repeat (3) step();
    #2 rst_n = 1'b1;
    repeat (3) step();
    checks++;
    if (vq.size() != 5 || dq.size() != 0) begin
      errors++; $display("FAIL midreset partial: got %0d samples %0d dones, expected 5 and 0", vq.size(), dq.size());
    end
    for (int i = 0; i < vq.size(); i++) begin
      checks++;
      if (vq[i].last !== 1'b0 || vq[i].idx !== MAW'(i)) begin
        errors++; $display("FAIL midreset sample %0d: got idx %0d last %b expected idx %0d last 0", i, vq[i].idx, vq[i].last, i);
      end
    end
    vq.delete(); rsq.delete(); dq.delete();
    run_frame(4'd3, 1, "post_reset");
  endtask

  task automatic test_stream_rules();
    checks++;
    if (bad_idle !== 0) begin errors++; $display("FAIL idle_zero: got %0d violations expected 0", bad_idle); end
    checks++;
    if (bad_hold !== 0) begin errors++; $display("FAIL out_hold: got %0d violations expected 0", bad_hold); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_random_frames();
    test_size_limits();
    test_saturation();
    test_back_to_back();
    test_reset_midframe();
    test_stream_rules();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
